data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Shares the single read/write port of the 32x256 data SRAM macro between two requesters: the Ibex core data port (requester 0) and an eFPGA fabric master driven through the UIO bus (requester 1).
- Implements the core's req/gnt/rvalid protocol on both sides.
- Performs round-robin arbitration, drives the macro's active-low control pins and routes the read response back to the owner.
- Sits between ibex_core, eFPGA_top and sky130_sram_1kbyte_1rw1r_32x256_8 port 0.

Parameters:
- ADDR_W, 8: SRAM word-address width; depth = 2**ADDR_W words.
- STAT_W, 16: width of contention counter (optional feature only).

Ports:
- clk  in  1  system clock; SRAM clk0 is tied to the same net.
- resetn  in  1  asynchronous active-low reset.
- r0_req, r1_req  in  1  request, held until granted.
- r0_gnt, r1_gnt  out  1  grant, combinational, same cycle.
- r0_we, r1_we  in  1  1 = write.
- r0_be, r1_be  in  4  byte enables.
- r0_addr, r1_addr  in  32  byte address.
- r0_wdata, r1_wdata  in  32  write data.
- r0_rvalid, r1_rvalid  out  1  response valid.
- r0_rdata, r1_rdata  out  32  read data.
- r0_err, r1_err  out  1  response error, qualified by rvalid.
- sram_csb0  out  1  chip select, active low.
- sram_web0  out  1  write enable, active low.
- sram_wmask0  out  4  write mask.
- sram_addr0  out  ADDR_W  word address.
- sram_din0  out  32  write data to macro.
- sram_dout0  in  32  read data from macro.
- conflict_cnt  out  STAT_W  present only with DATA_ARB_STATS_EN.

Behaviour:
- Reset is asynchronous, active low. During and after reset: rr_ptr=0, rsp_valid=0, rsp_owner=0, rsp_err=0. Resulting outputs: both rvalid=0, both err=0, sram_csb0=1, sram_web0=1.
- At most one access per cycle. Throughput is 1 access per cycle with no bubbles.
- Arbitration (combinational):
  - Only rN_req high: grant N.
  - Both high: grant requester rr_ptr.
  - Neither high: no grant, sram_csb0=1.
- rr_ptr update: on any grant to N, rr_ptr <= ~N at the next edge. A requester therefore waits at most one cycle under continuous contention.
- Address check:
  - Word address = addr[ADDR_W+1:2]. addr[1:0] are ignored.
  - Out of range when addr[31:ADDR_W+2] != 0. The grant is still given, sram_csb0 stays 1, and the response carries err=1 with rdata=0.
- SRAM drive, in the grant cycle, for an in-range access:
  - sram_csb0=0.
  - sram_web0=~we.
  - sram_wmask0=be.
  - sram_din0=wdata.
  - sram_addr0=word address.
  - When not selected, addr/din/wmask are muxed from the winner or held at the requester-0 values; their content is don't-care.
- Response:
  - Registered: rsp_valid, rsp_owner and rsp_err are set at the edge ending the grant cycle.
  - rvalid(owner)=1 exactly one cycle after gnt, for both reads and writes.
  - Read data is sram_dout0 in that cycle.
  - The non-owner sees rvalid=0.
  - rdata is driven as sram_dout0 gated to 0 when the requester is not the owner or when err=1.
- Back-to-back: a grant in cycle t+1 coexists with the rvalid for the grant of cycle t; the response register is overwritten every cycle.
- Write followed by read of the same address in consecutive cycles returns the new data. This relies on macro ordering; the arbiter adds no forwarding.
- Reset mid-operation: a pending response is discarded and no rvalid is emitted after resetn rises. Requesters must reissue.
- No write after a request has been granted; the gnt cycle commits the access.

Optional Feature:
- Macro: DATA_ARB_STATS_EN.
- Defined:
  - Adds port conflict_cnt, which increments by 1 in every cycle where r0_req and r1_req are both high.
  - Saturates at all-ones.
  - Cleared by reset only.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Core read only: r0_req=1, addr=0x0000_0010, we=0 -> same cycle r0_gnt=1, sram_csb0=0, sram_web0=1, sram_addr0=0x04; next cycle r0_rvalid=1, r0_rdata=word 4 contents, r1_rvalid=0.
- Fabric write then core read: r1 writes 0xDEADBEEF, be=4'hF to 0x20; next cycle r0 reads 0x20 -> r1_rvalid=1 with err=0; one cycle later r0_rdata=0xDEADBEEF.
- Contention: both req held 6 cycles after reset -> grants alternate r0,r1,r0,r1,r0,r1; each rvalid goes to the correct owner one cycle later; with DATA_ARB_STATS_EN, conflict_cnt=6.
- Out of range: r1 reads 0x0000_0400 -> r1_gnt=1, sram_csb0 stays 1, next cycle r1_rvalid=1, r1_err=1, r1_rdata=0.
- Byte write: r0 writes 0x11223344 with be=4'b0100 over 0xFFFFFFFF at 0x08 -> sram_wmask0=4'b0100; a read of 0x08 returns 0xFF22FFFF.
- Reset mid-access: grant r0 read, assert resetn=0 before the next edge -> r0_rvalid and r1_rvalid stay 0 through and after reset; sram_csb0=1; conflict_cnt=0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bundle between the two data requesters (Ibex core, eFPGA fabric) and the SRAM port-0 pins.
// Latency: wires only. Backpressure: requesters hold rN_req until rN_gnt is seen.
// Parameter ADDR_W is the SRAM word-address width; it must match the arbiter's ADDR_W.
// Modports:
//   slave  - the arbiter: samples requests and macro read data, drives grants/responses and macro pins.
//   master - the environment: drives requests and macro read data, observes everything else.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8
) ();
    // Requester 0: Ibex core data port
    logic              r0_req;
    logic              r0_gnt;
    logic              r0_we;
    logic [3:0]        r0_be;
    logic [31:0]       r0_addr;
    logic [31:0]       r0_wdata;
    logic              r0_rvalid;
    logic [31:0]       r0_rdata;
    logic              r0_err;

    // Requester 1: eFPGA fabric master on the UIO bus
    logic              r1_req;
    logic              r1_gnt;
    logic              r1_we;
    logic [3:0]        r1_be;
    logic [31:0]       r1_addr;
    logic [31:0]       r1_wdata;
    logic              r1_rvalid;
    logic [31:0]       r1_rdata;
    logic              r1_err;

    // SRAM macro port 0 (control pins active low)
    logic              sram_csb0;
    logic              sram_web0;
    logic [3:0]        sram_wmask0;
    logic [ADDR_W-1:0] sram_addr0;
    logic [31:0]       sram_din0;
    logic [31:0]       sram_dout0;

    modport slave (
        input  r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_be, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_dout0
    );

    modport master (
        output r0_req, r0_we, r0_be, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_we, r1_be, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_dout0
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single rw port of the 32x256 data SRAM between core (r0) and fabric (r1).
// Latency: grant combinational in the request cycle; rvalid exactly one cycle after grant, 1 access/cycle.
// Backpressure: a losing requester keeps rN_req high; under contention it waits at most one cycle.
// Ports: clk, resetn (async active low), bus (data_mem_arbiter_if.slave: both requester
//   req/gnt/rvalid channels plus SRAM port-0 pins), conflict_cnt (only with DATA_ARB_STATS_EN).
// Optional feature macro: DATA_ARB_STATS_EN adds a saturating count of cycles with both requests high.
module data_mem_arbiter #(
    parameter int ADDR_W = 8
`ifdef DATA_ARB_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    data_mem_arbiter_if.slave bus
`ifdef DATA_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] conflict_cnt
`endif
);

    // r_rr_ptr: requester that wins the next tie
    logic        r_rr_ptr;
    logic        r_rsp_valid;
    logic        r_rsp_owner;
    logic        r_rsp_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_oor;
    logic        w_sel;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_own0;
    logic        w_own1;
    logic        w_unused;

    // Arbitration: a lone request always wins; a tie goes to r_rr_ptr.
    assign w_gnt0    = bus.r0_req & (~bus.r1_req | ~r_rr_ptr);
    assign w_gnt1    = bus.r1_req & (~bus.r0_req |  r_rr_ptr);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign bus.r0_gnt = w_gnt0;
    assign bus.r1_gnt = w_gnt1;

    // Winner's fields; requester-0 values pass through when nobody is granted.
    assign w_we    = w_gnt1 ? bus.r1_we    : bus.r0_we;
    assign w_be    = w_gnt1 ? bus.r1_be    : bus.r0_be;
    assign w_addr  = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign w_wdata = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;

    // Byte address above the macro depth: granted, but the macro is not selected.
    assign w_oor = |w_addr[31:ADDR_W+2];
    assign w_sel = w_any_gnt & ~w_oor;

    // Byte offset within the word carries no meaning for a word-wide macro.
    assign w_unused = ^w_addr[1:0];

    assign bus.sram_csb0   = ~w_sel;
    assign bus.sram_web0   = ~(w_sel & w_we);
    assign bus.sram_wmask0 = w_be;
    assign bus.sram_addr0  = w_addr[ADDR_W+1:2];
    assign bus.sram_din0   = w_wdata;

    // Pointer and response register. The response is rewritten every cycle, so a grant
    // in cycle t+1 overlaps the rvalid for cycle t without any queueing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rr_ptr    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Hand the next tie to whoever did not just win.
            if (w_any_gnt) begin
                r_rr_ptr <= w_gnt0;
            end
            r_rsp_valid <= w_any_gnt;
            r_rsp_owner <= w_gnt1;
            r_rsp_err   <= w_any_gnt & w_oor;
        end
    end

    assign w_own0 = r_rsp_valid & ~r_rsp_owner;
    assign w_own1 = r_rsp_valid &  r_rsp_owner;

    assign bus.r0_rvalid = w_own0;
    assign bus.r1_rvalid = w_own1;
    assign bus.r0_err    = w_own0 & r_rsp_err;
    assign bus.r1_err    = w_own1 & r_rsp_err;

    // Macro output is already registered inside the SRAM, so it lines up with rvalid.
    assign bus.r0_rdata = (~r_rsp_owner & ~r_rsp_err) ? bus.sram_dout0 : 32'h0;
    assign bus.r1_rdata = ( r_rsp_owner & ~r_rsp_err) ? bus.sram_dout0 : 32'h0;

`ifdef DATA_ARB_STATS_EN
    logic [STAT_W-1:0] r_conflict_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_conflict_cnt <= '0;
        end else if (bus.r0_req && bus.r1_req && !(&r_conflict_cnt)) begin
            r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: behavioural SRAM macro, directed scenarios and
// randomized two-requester traffic compared against a transaction-level reference model.
module tb_data_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef DATA_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    data_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef DATA_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // ---------------- behavioural SRAM macro (registered read, masked write) ----------------
    logic [31:0]       mem [DEPTH];
    logic [31:0]       sram_dout;
    logic              init_en;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_dat;

    always @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= init_dat;
        end else if (!bus.sram_csb0) begin
            if (!bus.sram_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.sram_wmask0[b]) mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
                end
            end else begin
                sram_dout <= mem[bus.sram_addr0];
            end
        end
    end
    assign bus.sram_dout0 = sram_dout;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH];
    bit          m_pv;      // a response is due this cycle
    int          m_po;      // its owner
    bit          m_pe;      // it is an error response
    bit          m_prd;     // it answers a read
    logic [31:0] m_pd;      // expected read data
    int          m_pref;    // who wins the next tie
    int          m_cnt;     // expected conflict count

    // Outstanding request of each requester
    bit          p_req [2];
    bit          p_we  [2];
    logic [3:0]  p_be  [2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wd  [2];

    task automatic set_txn(input int r, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd);
        p_req[r] = 1'b1; p_we[r] = we; p_be[r] = be; p_addr[r] = addr; p_wd[r] = wd;
    endtask

    task automatic new_txn(input int r);
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) begin
            a = $urandom;
            if ((a >> (ADDR_W + 2)) == 0) a[31] = 1'b1;
        end else begin
            a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        end
        set_txn(r, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom);
    endtask

    task automatic apply();
        bus.r0_req = p_req[0]; bus.r0_we = p_we[0]; bus.r0_be = p_be[0];
        bus.r0_addr = p_addr[0]; bus.r0_wdata = p_wd[0];
        bus.r1_req = p_req[1]; bus.r1_we = p_we[1]; bus.r1_be = p_be[1];
        bus.r1_addr = p_addr[1]; bus.r1_wdata = p_wd[1];
    endtask

    // Called just after a negedge with inputs applied: check this cycle, then advance the model.
    task automatic eval();
        int          win;
        int          w;
        logic [31:0] a;
        bit          inr;
        #1;
        if (p_req[0] && p_req[1]) win = m_pref;
        else if (p_req[0])        win = 0;
        else if (p_req[1])        win = 1;
        else                      win = -1;

        chk("r0_gnt", 32'(bus.r0_gnt), 32'(win == 0));
        chk("r1_gnt", 32'(bus.r1_gnt), 32'(win == 1));

        chk("r0_rvalid", 32'(bus.r0_rvalid), 32'(m_pv && m_po == 0));
        chk("r1_rvalid", 32'(bus.r1_rvalid), 32'(m_pv && m_po == 1));
        chk("r0_err", 32'(bus.r0_err), 32'(m_pv && m_po == 0 && m_pe));
        chk("r1_err", 32'(bus.r1_err), 32'(m_pv && m_po == 1 && m_pe));
        if (m_pv) begin
            if (m_po == 0) chk("r1_rdata_nonowner", bus.r1_rdata, 32'h0);
            else           chk("r0_rdata_nonowner", bus.r0_rdata, 32'h0);
            if (m_pe || m_prd) begin
                if (m_po == 0) chk("r0_rdata", bus.r0_rdata, m_pe ? 32'h0 : m_pd);
                else           chk("r1_rdata", bus.r1_rdata, m_pe ? 32'h0 : m_pd);
            end
        end

        a   = (win >= 0) ? p_addr[win] : 32'h0;
        inr = (win >= 0) && ((a >> (ADDR_W + 2)) == 0);
        w   = int'((a >> 2) % DEPTH);
        chk("sram_csb0", 32'(bus.sram_csb0), 32'(!inr));
        if (inr) begin
            chk("sram_web0",   32'(bus.sram_web0),   32'(!p_we[win]));
            chk("sram_wmask0", 32'(bus.sram_wmask0), 32'(p_be[win]));
            chk("sram_din0",   bus.sram_din0,        p_wd[win]);
            chk("sram_addr0",  32'(bus.sram_addr0),  32'(w));
        end
`ifdef DATA_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif

        if (!resetn) begin
            m_pv = 1'b0; m_pref = 0; m_cnt = 0;
        end else begin
            if (p_req[0] && p_req[1] && m_cnt < 65535) m_cnt++;
            m_pv = (win >= 0);
            if (win >= 0) begin
                m_po  = win;
                m_pe  = !inr;
                m_prd = !p_we[win];
                if (inr) begin
                    m_pd = ref_mem[w];
                    if (p_we[win]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (p_be[win][b]) ref_mem[w][8*b +: 8] = p_wd[win][8*b +: 8];
                        end
                    end
                end
                m_pref = 1 - win;
                p_req[win] = 1'b0;
            end
        end
    endtask

    task automatic step();
        apply();
        eval();
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle; any pending response must vanish and never reappear.
    task automatic mid_reset();
        resetn = 1'b0;
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        apply();
        m_pv = 1'b0; m_pref = 0; m_cnt = 0;
        eval();
        chk("rst_web0", 32'(bus.sram_web0), 32'h1);
        @(negedge clk);
        eval();
        @(negedge clk);
        resetn = 1'b1;
        eval();
        @(negedge clk);
        eval();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn  = 1'b0;
        init_en = 1'b0;
        for (int r = 0; r < 2; r++) set_txn(r, 1'b0, 4'h0, 32'h0, 32'h0);
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        apply();
        m_pv = 1'b0; m_po = 0; m_pe = 1'b0; m_prd = 1'b0; m_pd = 32'h0; m_pref = 0; m_cnt = 0;

        // Backdoor preload of the macro and the model
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            init_en   = 1'b1;
            init_addr = ADDR_W'(i);
            init_dat  = $urandom;
            ref_mem[i] = init_dat;
        end
        @(negedge clk);
        init_en = 1'b0;

        // Reset state
        eval();
        chk("rst_web0", 32'(bus.sram_web0), 32'h1);
        @(negedge clk);
        resetn = 1'b1;

        // Contention right after reset: both held for six cycles
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++) if (!p_req[r]) new_txn(r);
            step();
        end
`ifdef DATA_ARB_STATS_EN
        chk("contention_cnt6", 32'(conflict_cnt), 32'd6);
`endif
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step();

        // Core read of word 4
        set_txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        step();
        step();

        // Fabric write then core read of the same word
        set_txn(1, 1'b1, 4'hF, 32'h0000_0020, 32'hDEAD_BEEF);
        step();
        set_txn(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
        step();
        chk("wr_then_rd", bus.r0_rdata, 32'hDEAD_BEEF);
        step();

        // Out-of-range fabric read
        set_txn(1, 1'b0, 4'hF, 32'h0000_0400, 32'h0);
        step();
        chk("oor_err", 32'(bus.r1_err), 32'h1);
        step();

        // Byte write over all-ones
        set_txn(0, 1'b1, 4'hF, 32'h0000_0008, 32'hFFFF_FFFF);
        step();
        set_txn(0, 1'b1, 4'b0100, 32'h0000_0008, 32'h1122_3344);
        step();
        set_txn(0, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
        step();
        chk("byte_write", bus.r0_rdata, 32'hFF22_FFFF);
        step();

        // Reset with a granted read in flight
        set_txn(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
        apply();
        eval();
        mid_reset();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_req[r] && $urandom_range(0, 3) != 0) new_txn(r);
            end
            step();
        end
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
